// File: rtl/psp_checker.sv
// psp_checker: receive-side PRBS7 (x^7 + x^6 + 1) checker.
// Self-synchronises to the incoming stream, declares lock after LOCK_N
// consecutive correct predictions, then counts bit errors against a
// free-running local replica. Lock is dropped when LOSS_N errors land
// in one WIN-bit monitoring window.
//
// Input qualifier: `in` is consumed only on cycles where in_valid is high.
// There is no ready/backpressure path; every valid bit is accepted. On
// cycles with in_valid low all state holds and err is 0. clr_cnt acts on
// every cycle, independent of in_valid.
module psp_checker #(
  parameter int LOCK_N = 16,
  parameter int WIN    = 64,
  parameter int LOSS_N = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [7:0]       LOCK_N_L = 8'(LOCK_N);
  localparam logic [7:0]       WIN_LAST = 8'(WIN - 1);
  localparam logic [7:0]       LOSS_N_L = 8'(LOSS_N);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           r_state;
  logic [6:0]       r_sr;
  logic [2:0]       r_fill;
  logic [7:0]       r_good;
  logic [7:0]       r_win;
  logic [7:0]       r_win_err;
  logic             r_locked;
  logic             r_err;
  logic [CNT_W-1:0] r_err_cnt;

  state_t           w_state_nxt;
  logic [6:0]       w_sr_nxt;
  logic [2:0]       w_fill_nxt;
  logic [7:0]       w_good_nxt;
  logic [7:0]       w_win_nxt;
  logic [7:0]       w_win_err_nxt;
  logic             w_err_nxt;

  logic             w_pred;
  logic             w_mis;
  logic [7:0]       w_good_inc;
  logic [7:0]       w_win_err_inc;

  // Next bit the local replica expects, and whether the received bit disagrees.
  assign w_pred = r_sr[6] ^ r_sr[5];
  assign w_mis  = in ^ w_pred;

  // An all-zero register is a degenerate PRBS state: it must never build up
  // a run of good predictions, so it forces the run length back to zero.
  assign w_good_inc    = ((r_sr == 7'd0) || w_mis) ? 8'd0 : (r_good + 8'd1);
  assign w_win_err_inc = r_win_err + {7'd0, w_mis};

  // Next-state and datapath update for the search/verify/locked FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_sr_nxt      = r_sr;
    w_fill_nxt    = r_fill;
    w_good_nxt    = r_good;
    w_win_nxt     = r_win;
    w_win_err_nxt = r_win_err;
    w_err_nxt     = 1'b0;
    if (in_valid) begin
      case (r_state)
        ST_SEARCH: begin
          w_sr_nxt = {r_sr[5:0], in};
          if (r_fill == 3'd6) begin
            w_fill_nxt  = 3'd0;
            w_good_nxt  = 8'd0;
            w_state_nxt = ST_VERIFY;
          end else begin
            w_fill_nxt = r_fill + 3'd1;
          end
        end
        ST_VERIFY: begin
          // Self-synchronise: the received bit always enters the register.
          w_sr_nxt   = {r_sr[5:0], in};
          w_good_nxt = w_good_inc;
          if (w_good_inc == LOCK_N_L) begin
            w_good_nxt    = 8'd0;
            w_win_nxt     = 8'd0;
            w_win_err_nxt = 8'd0;
            w_state_nxt   = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          // Free-run on the prediction so one bad bit cannot corrupt later ones.
          w_sr_nxt  = {r_sr[5:0], w_pred};
          w_err_nxt = w_mis;
          if (w_win_err_inc == LOSS_N_L) begin
            w_fill_nxt    = 3'd0;
            w_win_nxt     = 8'd0;
            w_win_err_nxt = 8'd0;
            w_state_nxt   = ST_SEARCH;
          end else if (r_win == WIN_LAST) begin
            w_win_nxt     = 8'd0;
            w_win_err_nxt = 8'd0;
          end else begin
            w_win_nxt     = r_win + 8'd1;
            w_win_err_nxt = w_win_err_inc;
          end
        end
        default: begin
          w_state_nxt = ST_SEARCH;
          w_fill_nxt  = 3'd0;
        end
      endcase
    end
  end

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_SEARCH;
      r_sr      <= 7'd0;
      r_fill    <= 3'd0;
      r_good    <= 8'd0;
      r_win     <= 8'd0;
      r_win_err <= 8'd0;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sr      <= w_sr_nxt;
      r_fill    <= w_fill_nxt;
      r_good    <= w_good_nxt;
      r_win     <= w_win_nxt;
      r_win_err <= w_win_err_nxt;
      r_locked  <= (w_state_nxt == ST_LOCKED);
      r_err     <= w_err_nxt;
    end
  end

  // Saturating error counter; a clear on the same cycle as an error wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (clr_cnt) begin
      r_err_cnt <= '0;
    end else if (w_err_nxt && (r_err_cnt != CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign locked    = r_locked;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;
  assign dbg_state = r_state;

endmodule

// File: doc/psp_checker.md
# psp_checker

Serial pseudo-random sequence (PSP) checker: the receive-side counterpart of the PSP generator register. Samples a PRBS7 bit stream (x^7 + x^6 + 1) one bit per valid cycle, self-synchronises to it, declares lock, then counts bit errors against a free-running local replica. It sits at the far end of a link or loopback and feeds lock status and error statistics to the test and status logic.

## Interface
- LOCK_N, default 16: consecutive correct predictions required to declare lock (range 1..255).
- WIN, default 64: length of the loss-of-lock monitoring window, in valid bits (range 2..255).
- LOSS_N, default 8: errors within one window that force loss of lock (range 1..WIN).
- CNT_W, default 16: width of the error counter.

- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in  in  1  received sequence bit.
- in_valid  in  1  `in` is sampled only when high; all state is held when low.
- clr_cnt  in  1  synchronous clear of `err_cnt`.
- locked  out  1  high while in LOCKED.
- err  out  1  one-cycle pulse per mismatched bit while LOCKED.
- err_cnt  out  CNT_W  saturating count of errors seen while LOCKED.

## Operation
- Shift register `sr[6:0]`; `sr[0]` is the newest bit. Prediction `p = sr[6] ^ sr[5]`. Each shift moves `sr` left and inserts a new bit at `sr[0]`.
- SEARCH: shift `in` into `sr` on every valid bit; fill counter 0..7. The 7th valid bit moves the block to VERIFY with `good_cnt = 0`.
- VERIFY: on each valid bit, compare `in` with `p`, then shift `in` into `sr` (self-sync).
  - A match increments `good_cnt`.
  - A mismatch clears `good_cnt`.
  - If `sr == 0` before the shift, `good_cnt` is cleared regardless of the comparison. An all-zero stream must never lock.
  - When `good_cnt` reaches LOCK_N, go to LOCKED and clear the window counter and window error count.
- LOCKED: on each valid bit, compare `in` with `p`, then shift `p` (not `in`) into `sr`, so single errors do not propagate.
  - A mismatch pulses `err`, increments `err_cnt` (saturating at 2^CNT_W-1) and increments `win_err`.
  - The window counter counts valid bits 0..WIN-1. At WIN-1 it wraps to 0 and `win_err` clears.
  - When `win_err` reaches LOSS_N, go to SEARCH and clear the fill counter. `sr` is not cleared; SEARCH refills it from new bits.
- `clr_cnt` clears `err_cnt` in any state. If `clr_cnt` and an error occur in the same cycle, `clr_cnt` wins: `err_cnt = 0` and that error is not counted, but `err` still pulses.
- `err_cnt` holds its value across lock loss. Only `rst` or `clr_cnt` clears it.

## Timing
- Reset values: state SEARCH, `sr = 0`, all internal counters 0, `locked = 0`, `err = 0`, `err_cnt = 0`. A `rst` asserted mid-operation takes effect at the next edge and overrides all other inputs.
- All outputs are registered.
  - `err` is high exactly in the cycle after the edge that sampled the bad bit.
  - `err_cnt` updates at the same edge as `err`.
- `locked` rises at the edge that samples the LOCK_N-th consecutive match. Minimum lock time from reset is 7 + LOCK_N valid bits; 23 with the defaults.
- `locked` falls at the edge that samples the LOSS_N-th error in a window. That bit is counted and pulses `err`.
- With `in_valid` low, state is frozen and `err` is 0.
- Throughput: one bit per clock. There is no backpressure.

## Test plan
- Reset, then clean PRBS7 (seed 7'b0000001) with `in_valid = 1` every cycle -> `locked` rises after exactly 23 bits; `err` stays 0 and `err_cnt = 0` over 1000 bits.
- Lock, then invert 3 isolated bits spaced more than 64 apart -> exactly 3 single-cycle `err` pulses, `err_cnt = 3`, `locked` stays 1.
- Lock, then invert 8 bits within one 64-bit window -> `locked` drops on the 8th error, `err_cnt = 8`, relock after 23 more clean bits.
- All-zero input for 200 bits -> `locked` never asserts, `err_cnt = 0`.
- Clean stream with `in_valid` toggling 1/0 each cycle -> lock after 23 valid bits (46 cycles). Assert `clr_cnt` in the same cycle as an injected error -> `err` pulses and `err_cnt = 0`.
- Assert `rst` for one cycle while locked with `err_cnt = 5` -> next cycle `locked = 0`, `err_cnt = 0`, and relock takes 23 bits.
